// File: rtl/jtriders_eeprom.sv
// +-------------------------------------------------------------------------+
// | jtriders_eeprom : 93C46-style serial EEPROM (x16) with host NVRAM port   |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

module jtriders_eeprom #(
   parameter int AW       = 6,
   parameter int BUSY_CYC = 64
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          scs,
   input  logic          sclk,
   input  logic          sdi,
   output logic          sdo,
   input  logic [AW-1:0] host_addr,
   input  logic [15:0]   host_din,
   input  logic          host_we,
   output logic [15:0]   host_dout
);

   localparam int c_words    = 2**AW;
   localparam int c_busy_all = (BUSY_CYC > c_words) ? BUSY_CYC : c_words;
   localparam int BCW        = $clog2(c_busy_all + 1) + 1;
   localparam logic [BCW-1:0] c_busy_m1     = BCW'(BUSY_CYC - 1);
   localparam logic [BCW-1:0] c_busy_all_m1 = BCW'(c_busy_all - 1);
   localparam logic [3:0]     c_cnt_addr    = 4'(AW - 1);
   localparam logic [AW-1:0]  c_last        = '1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_OPC   = 3'd2,
      S_ADDR  = 3'd3,
      S_DIN   = 3'd4,
      S_DOUT  = 3'd5,
      S_BUSY  = 3'd6,
      S_HOLD  = 3'd7
   } state_t;

   logic [15:0]    r_mem [c_words];

   state_t         r_state, w_state_nx;
   logic           r_sdo, w_sdo_nx;
   logic           r_sclk_d;
   logic [3:0]     r_cnt, w_cnt_nx;
   logic [1:0]     r_opc, w_opc_nx;
   logic [AW-1:0]  r_addr, w_addr_nx;
   logic [14:0]    r_din, w_din_nx;
   logic [15:0]    r_shift, w_shift_nx;
   logic           r_wen, w_wen_nx;
   logic [BCW-1:0] r_bcnt, w_bcnt_nx;
   logic           r_bulk, w_bulk_nx;
   logic [AW-1:0]  r_wptr, w_wptr_nx;
   logic [15:0]    r_bdata, w_bdata_nx;

   logic           w_edge;
   logic [AW-1:0]  w_addr_sh, w_addr_inc;
   logic [15:0]    w_din_sh;
   logic           w_commit, w_commit_all;
   logic [AW-1:0]  w_commit_addr;
   logic [15:0]    w_commit_data;
   logic           w_ser_we;
   logic [AW-1:0]  w_ser_addr;
   logic [15:0]    w_ser_data;
   logic           w_mem_we;
   logic [AW-1:0]  w_mem_addr;
   logic [15:0]    w_mem_data;

   assign w_edge     = scs & sclk & ~r_sclk_d;
   assign w_addr_sh  = {r_addr[AW-2:0], sdi};
   assign w_addr_inc = r_addr + AW'(1);
   assign w_din_sh   = {r_din, sdi};
   assign sdo        = r_sdo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_sdo    <= 1'b1;
         r_sclk_d <= 1'b0;
         r_cnt    <= '0;
         r_opc    <= '0;
         r_addr   <= '0;
         r_din    <= '0;
         r_shift  <= '0;
         r_wen    <= 1'b0;
         r_bcnt   <= '0;
         r_bulk   <= 1'b0;
         r_wptr   <= '0;
         r_bdata  <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_sdo    <= w_sdo_nx;
         r_sclk_d <= sclk;
         r_cnt    <= w_cnt_nx;
         r_opc    <= w_opc_nx;
         r_addr   <= w_addr_nx;
         r_din    <= w_din_nx;
         r_shift  <= w_shift_nx;
         r_wen    <= w_wen_nx;
         r_bcnt   <= w_bcnt_nx;
         r_bulk   <= w_bulk_nx;
         r_wptr   <= w_wptr_nx;
         r_bdata  <= w_bdata_nx;
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      w_sdo_nx      = r_sdo;
      w_cnt_nx      = r_cnt;
      w_opc_nx      = r_opc;
      w_addr_nx     = r_addr;
      w_din_nx      = r_din;
      w_shift_nx    = r_shift;
      w_wen_nx      = r_wen;
      w_bcnt_nx     = r_bcnt;
      w_bulk_nx     = r_bulk;
      w_wptr_nx     = r_wptr;
      w_bdata_nx    = r_bdata;
      w_commit      = 1'b0;
      w_commit_all  = 1'b0;
      w_commit_addr = r_addr;
      w_commit_data = 16'hFFFF;
      w_ser_we      = 1'b0;
      w_ser_addr    = r_addr;
      w_ser_data    = r_bdata;

      case (r_state)
         S_IDLE: begin
            w_sdo_nx = 1'b1;
            if (scs) w_state_nx = S_START;
         end
         S_START: begin
            if (w_edge && sdi) begin
               w_state_nx = S_OPC;
               w_cnt_nx   = '0;
            end
         end
         S_OPC: begin
            if (w_edge) begin
               w_opc_nx = {r_opc[0], sdi};
               if (r_cnt == 4'd1) begin
                  w_state_nx = S_ADDR;
                  w_cnt_nx   = '0;
               end else begin
                  w_cnt_nx = r_cnt + 4'd1;
               end
            end
         end
         S_ADDR: begin
            if (w_edge) begin
               w_addr_nx = w_addr_sh;
               if (r_cnt == c_cnt_addr) begin
                  w_cnt_nx      = '0;
                  w_commit_addr = w_addr_sh;
                  case (r_opc)
                     2'b10: begin
                        // sdo goes low next clk as the dummy bit
                        w_state_nx = S_DOUT;
                        w_sdo_nx   = 1'b0;
                        w_shift_nx = r_mem[w_addr_sh];
                     end
                     2'b01: w_state_nx = S_DIN;
                     2'b11: w_commit   = 1'b1;
                     default: begin
                        case (w_addr_sh[AW-1:AW-2])
                           2'b11: begin
                              w_wen_nx   = 1'b1;
                              w_state_nx = S_HOLD;
                           end
                           2'b00: begin
                              w_wen_nx   = 1'b0;
                              w_state_nx = S_HOLD;
                           end
                           2'b01: w_state_nx = S_DIN;
                           default: begin
                              w_commit     = 1'b1;
                              w_commit_all = 1'b1;
                           end
                        endcase
                     end
                  endcase
               end else begin
                  w_cnt_nx = r_cnt + 4'd1;
               end
            end
         end
         S_DIN: begin
            if (w_edge) begin
               w_din_nx = w_din_sh[14:0];
               if (r_cnt == 4'd15) begin
                  w_cnt_nx      = '0;
                  w_commit      = 1'b1;
                  w_commit_all  = (r_opc == 2'b00);
                  w_commit_data = w_din_sh;
               end else begin
                  w_cnt_nx = r_cnt + 4'd1;
               end
            end
         end
         S_DOUT: begin
            if (w_edge) begin
               w_sdo_nx = r_shift[15];
               if (r_cnt == 4'd15) begin
                  w_cnt_nx   = '0;
                  w_addr_nx  = w_addr_inc;
                  w_shift_nx = r_mem[w_addr_inc];
               end else begin
                  w_cnt_nx   = r_cnt + 4'd1;
                  w_shift_nx = {r_shift[14:0], 1'b0};
               end
            end
         end
         S_BUSY: begin
            if (r_bulk) begin
               w_ser_we   = 1'b1;
               w_ser_addr = r_wptr;
               w_ser_data = r_bdata;
               w_wptr_nx  = r_wptr + AW'(1);
               if (r_wptr == c_last) w_bulk_nx = 1'b0;
            end
            if (r_bcnt == '0 && (!r_bulk || r_wptr == c_last)) begin
               w_sdo_nx   = 1'b1;
               w_state_nx = scs ? S_HOLD : S_IDLE;
            end else begin
               w_sdo_nx  = 1'b0;
               w_bcnt_nx = r_bcnt - BCW'(1);
            end
         end
         S_HOLD: w_sdo_nx = 1'b1;
         default: begin
            w_state_nx = S_IDLE;
            w_sdo_nx   = 1'b1;
         end
      endcase

      // With the write-enable latch clear a commit is silently dropped
      if (w_commit) begin
         if (r_wen) begin
            w_state_nx = S_BUSY;
            w_sdo_nx   = 1'b0;
            if (w_commit_all) begin
               w_bulk_nx  = 1'b1;
               w_wptr_nx  = '0;
               w_bdata_nx = w_commit_data;
               w_bcnt_nx  = c_busy_all_m1;
            end else begin
               w_ser_we   = 1'b1;
               w_ser_addr = w_commit_addr;
               w_ser_data = w_commit_data;
               w_bcnt_nx  = c_busy_m1;
            end
         end else begin
            w_state_nx = S_HOLD;
            w_sdo_nx   = 1'b1;
         end
      end

      if (!scs && r_state != S_BUSY) begin
         w_state_nx = S_IDLE;
         w_sdo_nx   = 1'b1;
      end
   end

   assign w_mem_we   = w_ser_we | host_we;
   assign w_mem_addr = w_ser_we ? w_ser_addr : host_addr;
   assign w_mem_data = w_ser_we ? w_ser_data : host_din;

   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
   end

   // Write-first bypass so a same-cycle write is visible on host_dout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         host_dout <= '0;
      else if (w_mem_we && w_mem_addr == host_addr)
         host_dout <= w_mem_data;
      else
         host_dout <= r_mem[host_addr];
   end

endmodule

`default_nettype wire

// File: doc/jtriders_eeprom.md
JTRIDERS_EEPROM -- requirements
Module: jtriders_eeprom

Interface
REQ-001 Parameter AW, default 6: word address width (64 words x16, 93C46 organisation).
REQ-002 Parameter BUSY_CYC, default 64: clk cycles that a program or erase operation reports busy.
REQ-003 clk  in  1  system clock; sole clock, all logic on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 scs  in  1  serial chip select from main CPU latch, active-high, synchronous to clk.
REQ-006 sclk  in  1  serial clock from main CPU latch, synchronous to clk.
REQ-007 sdi  in  1  serial data into EEPROM.
REQ-008 sdo  out  1  serial data out; also ready(1)/busy(0) status.
REQ-009 host_addr  in  AW  NVRAM load/save word address.
REQ-010 host_din  in  16  NVRAM load data.
REQ-011 host_we  in  1  NVRAM load write strobe.
REQ-012 host_dout  out  16  registered read of word host_addr, one-cycle latency.

Function
REQ-013 A rising edge of sclk is detected as sclk=1 while previous-cycle sclk=0, and SHALL be acted on only while scs=1.
REQ-014 Only sclk rising edges SHALL sample sdi.
REQ-015 FSM states: IDLE, START, OPC, ADDR, DIN, DOUT, BUSY, HOLD.
REQ-016 scs=0 in any state except BUSY SHALL return the FSM to IDLE on the next clk; scs=0 in BUSY SHALL be ignored.
REQ-017 IDLE -> START when scs=1.
REQ-018 START: edges with sdi=0 are ignored; the first edge with sdi=1 goes to OPC.
REQ-019 OPC: shift 2 opcode bits MSB first -> ADDR.
REQ-020 ADDR: shift AW address bits MSB first, then decode.
REQ-021 READ (10) -> DOUT; WRITE (01) -> DIN; ERASE (11) commits FFFF to the address.
REQ-022 Opcode 00 decodes on addr[AW-1:AW-2]: 11 EWEN sets the write-enable latch, 00 EWDS clears it, 01 WRAL -> DIN, 10 ERAL commits FFFF to all words.
REQ-023 EWEN and EWDS -> HOLD.
REQ-024 DIN: shift 16 bits MSB first; after the 16th bit, commit WRITE to the address, or WRAL to all words -> BUSY.
REQ-025 ERASE and ERAL commit at address decode -> BUSY.
REQ-026 A commit SHALL modify memory only when the write-enable latch is 1; when the latch is 0, the FSM goes to HOLD and sdo stays 1.
REQ-027 WRAL/ERAL SHALL complete all 2^AW word writes, one per clk, before leaving BUSY.
REQ-028 BUSY: sdo=0 for BUSY_CYC cycles counted from the commit (minimum 2^AW for WRAL/ERAL).
REQ-029 On BUSY expiry, sdo=1; go to HOLD if scs=1, else IDLE.
REQ-030 DOUT: one clk after the edge sampling the last address bit, sdo=0 (dummy bit).
REQ-031 DOUT: each following sclk edge SHALL drive the next data bit MSB first, one clk after the edge.
REQ-032 DOUT: after bit 0, the address SHALL increment modulo 2^AW and the stream continues seamlessly with the next word.
REQ-033 HOLD ignores sclk until scs=0.
REQ-034 sdo=1 in IDLE, START, OPC, ADDR, DIN and HOLD.
REQ-035 Host port writes when host_we=1; on the same cycle as a serial commit, the serial write wins and the host write is dropped.
REQ-036 host_dout SHALL reflect a same-cycle serial write to host_addr one cycle later.

Reset
REQ-037 rst_n=0: FSM=IDLE, sdo=1, shift registers and counters=0, write-enable latch=0, host_dout=0; memory contents retained.
REQ-038 rst_n deasserted mid-command: the operation is abandoned, no partial write, and a new command requires a start bit.

Verification
REQ-039 Load word 5=1234h via host port; serial READ addr 5 -> sdo shows 0 then 0001001000110100b; continue 16 more edges -> host-loaded word 6.
REQ-040 WRITE addr 3 data BEEFh without EWEN -> sdo stays 1, word 3 unchanged; after EWEN, same WRITE -> sdo=0 for 64 cycles, host_dout at 3 = BEEFh.
REQ-041 EWEN, ERAL -> all 64 words FFFFh; EWEN, WRAL 00A5h -> all words 00A5h, busy >= 64 cycles.
REQ-042 READ addr 63, 32 data edges -> word 63 then word 0 (wrap).
REQ-043 scs dropped after 4 address bits, then full READ addr 2 -> correct word 2; rst_n pulse during DIN -> no memory change, sdo=1.
REQ-044 Host write to addr 7 on the same cycle as a serial WRITE commit to addr 7 with 5555h -> word 7 = 5555h.
